// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data RAM for the RV32 core with per-byte write
// enables, a valid/ready request port and a registered response delivered a
// fixed number of cycles after acceptance. Out-of-range and misaligned
// accesses are reported as errors and counted in a saturating counter.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_we,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  err_count
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [1:0]  CNT_LOAD   = 2'(LATENCY - 1);
  localparam bit          DIRECT     = (LATENCY == 1);

  // Saturating increment used by the error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Storage: not reset, so contents survive a reset pulse.
  logic [31:0] mem_q [0:DEPTH_WORDS-1];

  // Control state (async reset).
  logic [1:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_count_q, err_count_d;

  // Response payload captured at acceptance and held until the response edge.
  logic [31:0] hold_rdata_q, hold_rdata_d;
  logic        hold_err_q, hold_err_d;

  // Request decode.
  logic             accept;
  logic [32:0]      diff;
  logic [31:0]      off;
  logic             below;
  logic             beyond;
  logic             misal;
  logic             acc_err;
  logic [IDX_W-1:0] idx;
  logic             is_wr;
  logic [31:0]      rd_word;
  logic [3:0]       lane_we;

  // Decode the incoming request: offset, word index, error and lane enables.
  always_comb begin
    accept  = req_valid && req_ready;
    // The borrow out of the 33-bit subtraction flags an address below the base.
    diff    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    below   = diff[32];
    off     = diff[31:0];
    beyond  = ({1'b0, off} >= SPAN_BYTES);
    misal   = (req_addr[1:0] != 2'b00);
    acc_err = below || beyond || misal;
    idx     = off[IDX_W+1:2];
    is_wr   = |req_we;
    rd_word = 32'h0;
    if (!acc_err && !is_wr) begin
      rd_word = mem_q[idx];
    end
    lane_we = (accept && !acc_err) ? req_we : 4'b0000;
  end

  // Byte-lane writes commit at the acceptance edge.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we[l]) begin
        mem_q[idx][8*l +: 8] <= req_wdata[8*l +: 8];
      end
    end
  end

  // Next-state logic for the latency counter, pending flag and response.
  always_comb begin
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    hold_rdata_d = hold_rdata_q;
    hold_err_d   = hold_err_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = 32'h0;
    rsp_err_d    = 1'b0;
    err_count_d  = err_count_q;

    if (pend_q) begin
      if (cnt_q == 2'd1) begin
        pend_d      = 1'b0;
        cnt_d       = 2'd0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = hold_rdata_q;
        rsp_err_d   = hold_err_q;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end

    // Acceptance only happens with pend_q low, so it never collides with the
    // expiry branch above.
    if (accept) begin
      if (DIRECT) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rd_word;
        rsp_err_d   = acc_err;
      end else begin
        pend_d       = 1'b1;
        cnt_d        = CNT_LOAD;
        hold_rdata_d = rd_word;
        hold_err_d   = acc_err;
      end
    end

    if (rsp_valid_d && rsp_err_d) begin
      err_count_d = sat_inc8(err_count_q);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 2'd0;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Held response payload; only consumed after it has been loaded.
  always_ff @(posedge clk) begin
    hold_rdata_q <= hold_rdata_d;
    hold_err_q   <= hold_err_d;
  end

  // Outputs: ready whenever nothing is in flight (including the response cycle).
  always_comb begin
    req_ready = !pend_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
    err_count = err_count_q;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl over four parameterisations.
//   inst 0: LATENCY=1, BASE=0,      DEPTH=1024
//   inst 1: LATENCY=3, BASE=0,      DEPTH=64
//   inst 2: LATENCY=2, BASE=0x1000, DEPTH=16
//   inst 3: LATENCY=4, BASE=0,      DEPTH=32
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst_n     = 4'hF;
  logic [3:0]       req_valid = 4'h0;
  logic [3:0]       req_ready;
  logic [3:0]       rsp_valid;
  logic [3:0]       rsp_err;
  logic [3:0][31:0] req_addr  = '0;
  logic [3:0][31:0] req_wdata = '0;
  logic [3:0][3:0]  req_we    = '0;
  logic [3:0][31:0] rsp_rdata;
  logic [3:0][7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          inst;
    int          cyc;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  exp_t        got_e;
  logic [31:0] mdl [4][0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_we(req_we[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .err_count(err_count[0]));

  dmem_ctrl #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0000), .LATENCY(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_we(req_we[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .err_count(err_count[1]));

  dmem_ctrl #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_we(req_we[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
    .err_count(err_count[2]));

  dmem_ctrl #(.DEPTH_WORDS(32), .BASE_ADDR(32'h0000_0000), .LATENCY(4)) u_dut3 (
    .clk(clk), .reset(rst_n[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_addr(req_addr[3]), .req_wdata(req_wdata[3]), .req_we(req_we[3]),
    .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]), .rsp_err(rsp_err[3]),
    .err_count(err_count[3]));

  function automatic int lat_of(input int i);
    case (i)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 2) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic longint depth_of(input int i);
    case (i)
      0: return 1024;
      1: return 64;
      2: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic bit model_err(input int i, input logic [31:0] a);
    logic [31:0] b;
    b = base_of(i);
    if (a < b) return 1'b1;
    if (longint'(a - b) >= depth_of(i) * 4) return 1'b1;
    return (a[1:0] != 2'b00);
  endfunction

  // Response monitor: pops the scoreboard on every response, checks idle zeros.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (rst_n[i] && rsp_valid[i] === 1'b1) begin
          checks++;
          if (expq.size() == 0 || expq[0].inst != i) begin
            errors++;
            $display("FAIL unexpected_rsp inst=%0d cyc=%0d: got rsp_valid=1, required none", i, cyc);
          end else begin
            got_e = expq.pop_front();
            if (got_e.cyc != cyc || rsp_err[i] !== got_e.err || rsp_rdata[i] !== got_e.rdata) begin
              errors++;
              $display("FAIL rsp inst=%0d: got cyc=%0d err=%b rdata=%h, required cyc=%0d err=%b rdata=%h",
                       i, cyc, rsp_err[i], rsp_rdata[i], got_e.cyc, got_e.err, got_e.rdata);
            end
          end
        end else begin
          checks++;
          if (rsp_valid[i] !== 1'b0 || rsp_err[i] !== 1'b0 || rsp_rdata[i] !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs inst=%0d cyc=%0d: got valid=%b err=%b rdata=%h, required 0/0/0",
                     i, cyc, rsp_valid[i], rsp_err[i], rsp_rdata[i]);
          end
        end
      end
      checks++;
      if (req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL lat1_ready cyc=%0d: got %b, required 1", cyc, req_ready[0]);
      end
    end
  end

  // Drive one request (called just after a rising edge), wait for acceptance,
  // update the model and queue the expected response.
  task automatic issue(input int i, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] we, input bit expect_rsp, output int acc_cyc);
    bit          e;
    int          idx;
    int          n;
    logic [31:0] rd;
    exp_t        x;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    req_we[i]    = we;
    req_valid[i] = 1'b1;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout inst=%0d: got req_ready=%b, required 1 within 20 cycles", i, req_ready[i]);
      req_valid[i] = 1'b0;
      acc_cyc = -1;
      return;
    end
    e   = model_err(i, addr);
    idx = e ? 0 : int'((addr - base_of(i)) >> 2);
    rd  = 32'h0;
    if (!e && we == 4'h0) rd = mdl[i][idx];
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!e) begin
      for (int l = 0; l < 4; l++) begin
        if (we[l]) mdl[i][idx][8*l +: 8] = wd[8*l +: 8];
      end
    end
    if (expect_rsp) begin
      x.inst  = i;
      x.cyc   = acc_cyc + lat_of(i) - 1;
      x.err   = e;
      x.rdata = rd;
      expq.push_back(x);
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output bit got);
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid[i] === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid[i] !== 1'b0 || rsp_err[i] !== 1'b0 || rsp_rdata[i] !== 32'h0 || err_count[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_state inst=%0d: got valid=%b err=%b rdata=%h cnt=%h, required all 0",
                 i, rsp_valid[i], rsp_err[i], rsp_rdata[i], err_count[i]);
      end
    end
    rst_n = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1111", req_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_word_rw();
    int a0, a1;
    issue(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, a0);
    issue(0, 32'h10, 32'h0, 4'h0, 1'b1, a1);
    checks++;
    if (a1 != a0 + 1) begin
      errors++;
      $display("FAIL word_rw_b2b: got accept gap %0d, required 1", a1 - a0);
    end
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL word_rw_read: got valid=%b rdata=%h, required 1/deadbeef", rsp_valid[0], rsp_rdata[0]);
    end
  endtask

  task automatic test_byte_lanes();
    int a;
    issue(0, 32'h20, 32'h1122_3344, 4'hF, 1'b1, a);
    issue(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1, a);
    issue(0, 32'h20, 32'h0, 4'h0, 1'b1, a);
    checks++;
    if (rsp_rdata[0] !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL byte_lanes_0101: got %h, required 11bb33dd", rsp_rdata[0]);
    end
    issue(0, 32'h20, 32'h7700_0000, 4'b1000, 1'b1, a);
    issue(0, 32'h20, 32'h0, 4'h0, 1'b1, a);
    checks++;
    if (rsp_rdata[0] !== 32'h77BB_33DD) begin
      errors++;
      $display("FAIL byte_lanes_1000: got %h, required 77bb33dd", rsp_rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    int a, a0, a1;
    bit got;
    issue(1, 32'h8, 32'hCAFE_F00D, 4'hF, 1'b1, a);
    issue(1, 32'h8, 32'h0, 4'h0, 1'b1, a0);
    // Hold the next request while the block is stalled.
    req_addr[1]  = 32'hC;
    req_wdata[1] = 32'h0BAD_C0DE;
    req_we[1]    = 4'hF;
    req_valid[1] = 1'b1;
    checks++;
    if (req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_c1: got req_ready=%b, required 0", req_ready[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_c2: got ready=%b valid=%b, required 0/0", req_ready[1], rsp_valid[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rsp_c3: got ready=%b valid=%b rdata=%h, required 1/1/cafef00d",
               req_ready[1], rsp_valid[1], rsp_rdata[1]);
    end
    issue(1, 32'hC, 32'h0BAD_C0DE, 4'hF, 1'b1, a1);
    checks++;
    if (a1 != a0 + 3) begin
      errors++;
      $display("FAIL b2b_accept: got offset %0d, required 3", a1 - a0);
    end
    wait_rsp(1, got);
    checks++;
    if (!got || cyc != a0 + 5) begin
      errors++;
      $display("FAIL b2b_rsp_cycle: got seen=%b offset=%0d, required 1/5", got, cyc - a0);
    end
    issue(1, 32'hC, 32'h0, 4'h0, 1'b1, a);
    wait_rsp(1, got);
  endtask

  task automatic test_errors();
    int a;
    bit got;
    issue(2, 32'h1000, 32'h0102_0304, 4'hF, 1'b1, a);
    issue(2, 32'h103C, 32'hA5A5_A5A5, 4'hF, 1'b1, a);
    issue(2, 32'h0FFC, 32'hFFFF_FFFF, 4'hF, 1'b1, a);
    issue(2, 32'h1040, 32'h0, 4'h0, 1'b1, a);
    issue(2, 32'h1002, 32'hFFFF_FFFF, 4'hF, 1'b1, a);
    wait_rsp(2, got);
    checks++;
    if (!got || rsp_err[2] !== 1'b1 || rsp_rdata[2] !== 32'h0 || err_count[2] !== 8'd3) begin
      errors++;
      $display("FAIL err_three: got seen=%b err=%b rdata=%h cnt=%0d, required 1/1/0/3",
               got, rsp_err[2], rsp_rdata[2], err_count[2]);
    end
    issue(2, 32'h1000, 32'h0, 4'h0, 1'b1, a);
    wait_rsp(2, got);
    checks++;
    if (rsp_rdata[2] !== 32'h0102_0304 || rsp_err[2] !== 1'b0) begin
      errors++;
      $display("FAIL err_mem_w0: got rdata=%h err=%b, required 01020304/0", rsp_rdata[2], rsp_err[2]);
    end
    issue(2, 32'h103C, 32'h0, 4'h0, 1'b1, a);
    wait_rsp(2, got);
    checks++;
    if (rsp_rdata[2] !== 32'hA5A5_A5A5 || rsp_err[2] !== 1'b0 || err_count[2] !== 8'd3) begin
      errors++;
      $display("FAIL err_last_word: got rdata=%h err=%b cnt=%0d, required a5a5a5a5/0/3",
               rsp_rdata[2], rsp_err[2], err_count[2]);
    end
  endtask

  task automatic test_saturation();
    int a;
    bit got;
    for (int k = 0; k < 252; k++) issue(2, 32'h2000 + 32'(k * 4), 32'h0, 4'h0, 1'b1, a);
    wait_rsp(2, got);
    checks++;
    if (err_count[2] !== 8'd255) begin
      errors++;
      $display("FAIL sat_reach: got %0d, required 255", err_count[2]);
    end
    for (int k = 0; k < 8; k++) issue(2, 32'h0000_0004, 32'h0, 4'h0, 1'b1, a);
    wait_rsp(2, got);
    checks++;
    if (err_count[2] !== 8'd255 || rsp_err[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: got cnt=%0d err=%b, required 255/1", err_count[2], rsp_err[2]);
    end
  endtask

  task automatic test_reset_mid();
    int a;
    bit got;
    issue(3, 32'h8, 32'h5A5A_1234, 4'hF, 1'b0, a);
    @(posedge clk); #1;
    rst_n[3] = 1'b0;
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[3] !== 1'b0 || req_ready[3] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_idle k=%0d: got valid=%b ready=%b, required 0/1", k, rsp_valid[3], req_ready[3]);
      end
    end
    issue(3, 32'h8, 32'h0, 4'h0, 1'b1, a);
    wait_rsp(3, got);
    checks++;
    if (!got || rsp_rdata[3] !== 32'h5A5A_1234) begin
      errors++;
      $display("FAIL reset_mid_data: got seen=%b rdata=%h, required 1/5a5a1234", got, rsp_rdata[3]);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_saturation();
    test_reset_mid();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding responses, required 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, latency-configurable data-memory block for the RV32 core. It replaces the fixed single-cycle data memory with a word-organised RAM that has per-byte write enables and a valid/ready request port. It returns a registered response after a programmable number of cycles and flags out-of-range or misaligned accesses. It sits between the core's load/store path and on-chip storage; the core stalls on `req_ready` low and consumes `rsp_valid` unconditionally.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; any value ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.
- `LATENCY`, 1: cycles from the acceptance cycle to the response cycle; legal range 1..4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, already lane-aligned by the core.
- `req_we` in 4: byte-lane write enables; 4'b0000 means read.
- `rsp_valid` out 1: one-cycle response pulse; there is no back-pressure.
- `rsp_rdata` out 32: read data. It is 0 for writes and for errors.
- `rsp_err` out 1: access error, qualified by `rsp_valid`.
- `err_count` out 8: saturating count of error responses.

## Operation
- **Accept.** A request is accepted at a rising edge where `req_valid` and `req_ready` are both 1. Request fields are sampled at that edge only.
- **Offset and index.** off = `req_addr` − `BASE_ADDR`, as 32-bit unsigned. The word index is off[31:2].
- **Error condition.** An error occurs when `req_addr` < `BASE_ADDR`, or off ≥ `DEPTH_WORDS`×4, or `req_addr[1:0]` ≠ 0.
  - On error, no lane is written, `rsp_rdata` = 0 and `rsp_err` = 1.
  - `err_count` increments at the response, saturating at 255.
- **Write** (`req_we` ≠ 0, no error).
  - Each enabled lane i writes `req_wdata[8i+7:8i]` into byte i of the word, at the acceptance edge.
  - Disabled lanes are unchanged. The response carries `rsp_rdata` = 0 and `rsp_err` = 0.
- **Read** (`req_we` = 0, no error). The word is captured at the acceptance edge and held until the response.
- **Read-after-write.** A read accepted after a write's acceptance edge sees the written data.
- **Single outstanding request.**
  - `req_ready` = 1 when idle or during the response cycle.
  - `req_ready` = 0 in the LATENCY−1 cycles between acceptance and response.
  - With `LATENCY` = 1, `req_ready` is constantly 1 and one access per cycle is sustained.
- **State.**
  - A 2-bit down-counter is loaded with LATENCY−1 on accept.
  - A pending flag is held while the counter runs.
  - `rsp_valid` is registered and is set the edge the counter expires.
- **Memory contents.** The storage array is not reset, so its contents are undefined after power-up and preserved across `reset`.

## Timing
- **Reset values.** While `reset` = 0: `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0, `err_count` = 0, counter and pending cleared, and `req_ready` = 1 from the cycle after deassertion.
- **Latency.** A request accepted in cycle N produces `rsp_valid` = 1 in cycle N+`LATENCY`, for exactly one cycle.
  - `rsp_rdata` and `rsp_err` are valid only in that cycle and read 0 otherwise.
- **Back-to-back.** A new request may be accepted in the response cycle N+`LATENCY`; its response lands at N+2×`LATENCY`.
- **Reset mid-operation.**
  - The pending request is dropped and no response is issued.
  - A write already committed at its acceptance edge stays in memory.
- **`req_valid` while not ready.** `req_valid` held while `req_ready` = 0 has no effect. The core must hold its request stable until accepted.
- **`err_count` at 255.** It stays at 255 on further errors and still reports `rsp_err` = 1.

## Test plan
- **Word write then read, `LATENCY`=1, `BASE_ADDR`=0.** Write 0xDEADBEEF to 0x10 with `req_we`=4'hF, then read 0x10 on the next cycle. Required: `rsp_valid` in cycles 1 and 2, second response `rsp_rdata`=0xDEADBEEF, `req_ready` constantly 1.
- **Byte lanes.** Pre-load 0x11223344 at 0x20, write 0xAABBCCDD with `req_we`=4'b0101, then read. Required: 0x11BB33DD.
- **`LATENCY`=3, stall and back-to-back.** Read accepted in cycle 0. Required: `req_ready`=0 in cycles 1–2; `rsp_valid` in cycle 3 only; a second request accepted in cycle 3 responds in cycle 6.
- **Errors, `BASE_ADDR`=0x1000, `DEPTH_WORDS`=16.** Issue accesses to 0x0FFC, 0x1040 and 0x1002. Required: each gives `rsp_err`=1 with `rsp_rdata`=0 and memory unchanged; `err_count`=3; access to 0x103C succeeds.
- **Saturation.** 260 error requests. Required: `err_count`=255.
- **Reset mid-request, `LATENCY`=4.** Write accepted in cycle 0; `reset` low in cycle 2. Required: no `rsp_valid` ever for that write, `req_ready`=1 after release, and a subsequent read returns the written data.
